// File: rtl/aesl_deadlock_param_monitor_if.sv
// Bundle of monitor inputs (per-instance idle/block, AXIS stall, control) and
// deadlock report outputs for one kernel-level deadlock monitor.
interface aesl_deadlock_param_monitor_if #(
  parameter int unsigned NUM_INST = 4,
  parameter int unsigned NUM_AXIS = 2,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned IDX_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;

  logic                en;
  logic                clr;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic                kernel_block;
  logic                kernel_block_pulse;
  logic [NUM_INST-1:0] block_snapshot;
  logic [IDX_W-1:0]    first_blocked_idx;
  logic [CNT_W-1:0]    block_event_cnt;

  modport master (
    output en, clr, inst_idle_sigs, inst_block_sigs, axis_block_sigs,
    input  kernel_block, kernel_block_pulse, block_snapshot, first_blocked_idx, block_event_cnt
  );

  modport slave (
    input  en, clr, inst_idle_sigs, inst_block_sigs, axis_block_sigs,
    output kernel_block, kernel_block_pulse, block_snapshot, first_blocked_idx, block_event_cnt
  );
endinterface

// File: rtl/aesl_deadlock_param_monitor.sv
// Kernel-level deadlock detector: declares BLOCKED once an internal-deadlock
// condition persists for TIMEOUT samples, with snapshot, culprit index and event count.
module aesl_deadlock_param_monitor #(
  parameter int unsigned NUM_INST = 4,
  parameter int unsigned NUM_AXIS = 2,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned STICKY   = 1,
  parameter int unsigned CNT_W    = 8
) (
  input logic                          kernel_monitor_clock,
  input logic                          kernel_monitor_reset_n,
  aesl_deadlock_param_monitor_if.slave mon
);
  localparam int unsigned IDX_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] ST_MONITOR = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [TMR_W-1:0]    timer_q;
  logic [TMR_W-1:0]    timer_d;
  logic                cond_c;
  logic                entry_c;
  logic [IDX_W-1:0]    low_idx_c;
  logic                block_q;
  logic                pulse_q;
  logic [NUM_INST-1:0] snap_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;

  // Internal deadlock: all instances idle or blocked, at least one blocked, no external stall.
  assign cond_c = mon.en
                & (&(mon.inst_idle_sigs | mon.inst_block_sigs))
                & (|mon.inst_block_sigs)
                & ~(|mon.axis_block_sigs);

  // Lowest set index of the blocked vector (scan from the top so the lowest wins).
  always_comb begin
    low_idx_c = '0;
    for (int i = NUM_INST - 1; i >= 0; i--) begin
      if (mon.inst_block_sigs[i]) low_idx_c = IDX_W'(i);
    end
  end

  // Persistence filter next-state; a clear on the would-be entry edge suppresses entry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    entry_c = 1'b0;
    case (state_q)
      ST_MONITOR: begin
        timer_d = '0;
        if (cond_c) begin
          if (TIMEOUT == 1) begin
            if (!mon.clr) begin
              state_d = ST_BLOCKED;
              entry_c = 1'b1;
            end
          end else begin
            state_d = ST_SUSPECT;
            timer_d = TMR_W'(1);
          end
        end
      end
      ST_SUSPECT: begin
        if (!cond_c) begin
          state_d = ST_MONITOR;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          if (!mon.clr) begin
            state_d = ST_BLOCKED;
            timer_d = '0;
            entry_c = 1'b1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_BLOCKED: begin
        timer_d = '0;
        if (!mon.en || mon.clr || ((STICKY == 0) && !cond_c)) state_d = ST_MONITOR;
      end
      default: begin
        state_d = ST_MONITOR;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset_n) begin
    if (!kernel_monitor_reset_n) begin
      state_q <= ST_MONITOR;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Report registers: captured on entry, zeroed by clr, count saturates.
  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset_n) begin
    if (!kernel_monitor_reset_n) begin
      block_q <= 1'b0;
      pulse_q <= 1'b0;
      snap_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      block_q <= (state_d == ST_BLOCKED);
      pulse_q <= entry_c;
      if (entry_c) begin
        snap_q <= mon.inst_block_sigs;
        idx_q  <= low_idx_c;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      end else if (mon.clr) begin
        snap_q <= '0;
        idx_q  <= '0;
      end
    end
  end

  assign mon.kernel_block       = block_q;
  assign mon.kernel_block_pulse = pulse_q;
  assign mon.block_snapshot     = snap_q;
  assign mon.first_blocked_idx  = idx_q;
  assign mon.block_event_cnt    = cnt_q;
endmodule

// File: tb/tb_aesl_deadlock_param_monitor.sv
// Scoreboard bench: four monitor variants share one stimulus stream; expected
// per-cycle outputs and hand-computed entry events are queued and checked by a monitor.
module tb_aesl_deadlock_param_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aesl_deadlock_param_monitor_if #(.NUM_INST(4), .NUM_AXIS(2), .CNT_W(8)) if0 ();
  aesl_deadlock_param_monitor_if #(.NUM_INST(4), .NUM_AXIS(2), .CNT_W(8)) if1 ();
  aesl_deadlock_param_monitor_if #(.NUM_INST(4), .NUM_AXIS(2), .CNT_W(2)) if2 ();
  aesl_deadlock_param_monitor_if #(.NUM_INST(4), .NUM_AXIS(2), .CNT_W(2)) if3 ();

  aesl_deadlock_param_monitor #(.NUM_INST(4), .NUM_AXIS(2), .TIMEOUT(16), .STICKY(1), .CNT_W(8)) dut_a (
    .kernel_monitor_clock(clk), .kernel_monitor_reset_n(rst_n), .mon(if0));
  aesl_deadlock_param_monitor #(.NUM_INST(4), .NUM_AXIS(2), .TIMEOUT(16), .STICKY(0), .CNT_W(8)) dut_b (
    .kernel_monitor_clock(clk), .kernel_monitor_reset_n(rst_n), .mon(if1));
  aesl_deadlock_param_monitor #(.NUM_INST(4), .NUM_AXIS(2), .TIMEOUT(4), .STICKY(1), .CNT_W(2)) dut_c (
    .kernel_monitor_clock(clk), .kernel_monitor_reset_n(rst_n), .mon(if2));
  aesl_deadlock_param_monitor #(.NUM_INST(4), .NUM_AXIS(2), .TIMEOUT(1), .STICKY(0), .CNT_W(2)) dut_d (
    .kernel_monitor_clock(clk), .kernel_monitor_reset_n(rst_n), .mon(if3));

  typedef struct packed {
    logic       blk;
    logic       pulse;
    logic [3:0] snap;
    logic [1:0] idx;
    logic [7:0] cnt;
  } exp_t;
  typedef exp_t [3:0] row_t;
  typedef struct packed {
    logic [3:0] snap;
    logic [1:0] idx;
    logic [7:0] cnt;
  } evt_t;

  localparam int TO   [4] = '{16, 16, 4, 1};
  localparam int ST   [4] = '{1, 0, 1, 0};
  localparam int CMAX [4] = '{255, 255, 3, 3};

  row_t exp_q[$];
  evt_t evt_q[$];
  exp_t m [4];
  int   m_run [4];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m[i] = '0;
      m_run[i] = 0;
    end
  endtask

  // Reference behaviour: count consecutive condition samples per variant.
  task automatic model_edge(input logic e, input logic c, input logic [3:0] idl,
                            input logic [3:0] bl, input logic [1:0] ax);
    logic cond;
    int lo;
    cond = e && (&(idl | bl)) && (|bl) && (ax == 2'b00);
    lo = -1;
    for (int b = 0; b < 4; b++) if (bl[b] && lo < 0) lo = b;
    for (int i = 0; i < 4; i++) begin
      m[i].pulse = 1'b0;
      if (m[i].blk) begin
        if (c) begin
          m[i].snap = '0;
          m[i].idx  = '0;
        end
        if (!e || c || (ST[i] == 0 && !cond)) m[i].blk = 1'b0;
        m_run[i] = 0;
      end else begin
        if (c) begin
          m[i].snap = '0;
          m[i].idx  = '0;
        end
        if (!cond) m_run[i] = 0;
        else if (m_run[i] + 1 >= TO[i] && !c) begin
          m[i].blk   = 1'b1;
          m[i].pulse = 1'b1;
          m[i].snap  = bl;
          m[i].idx   = 2'(lo);
          if (int'(m[i].cnt) < CMAX[i]) m[i].cnt = m[i].cnt + 8'd1;
          m_run[i] = 0;
        end else begin
          m_run[i] = (m_run[i] + 1 >= TO[i]) ? TO[i] - 1 : m_run[i] + 1;
        end
      end
    end
  endtask

  task automatic set_in(input logic e, input logic c, input logic [3:0] idl,
                        input logic [3:0] bl, input logic [1:0] ax);
    if0.en = e; if0.clr = c; if0.inst_idle_sigs = idl; if0.inst_block_sigs = bl; if0.axis_block_sigs = ax;
    if1.en = e; if1.clr = c; if1.inst_idle_sigs = idl; if1.inst_block_sigs = bl; if1.axis_block_sigs = ax;
    if2.en = e; if2.clr = c; if2.inst_idle_sigs = idl; if2.inst_block_sigs = bl; if2.axis_block_sigs = ax;
    if3.en = e; if3.clr = c; if3.inst_idle_sigs = idl; if3.inst_block_sigs = bl; if3.axis_block_sigs = ax;
  endtask

  // One cycle: apply inputs just after an edge, queue expected state for the coming negedge.
  task automatic step(input logic r, input logic e, input logic c, input logic [3:0] idl,
                      input logic [3:0] bl, input logic [1:0] ax);
    row_t row;
    rst_n = r;
    set_in(e, c, idl, bl, ax);
    if (!r) model_reset();
    for (int i = 0; i < 4; i++) row[i] = m[i];
    exp_q.push_back(row);
    @(posedge clk);
    if (r) model_edge(e, c, idl, bl, ax);
    #1;
  endtask

  task automatic run(input int n, input logic r, input logic e, input logic c, input logic [3:0] idl,
                     input logic [3:0] bl, input logic [1:0] ax);
    for (int k = 0; k < n; k++) step(r, e, c, idl, bl, ax);
  endtask

  function automatic exp_t actual(input logic b, input logic p, input logic [3:0] s,
                                  input logic [1:0] x, input logic [7:0] n);
    actual = {b, p, s, x, n};
  endfunction

  // Monitor: per-cycle compare of every variant, plus entry-event check on variant A.
  row_t e_row;
  row_t a_row;
  evt_t e_evt;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_row = exp_q.pop_front();
      a_row[0] = actual(if0.kernel_block, if0.kernel_block_pulse, if0.block_snapshot, if0.first_blocked_idx, 8'(if0.block_event_cnt));
      a_row[1] = actual(if1.kernel_block, if1.kernel_block_pulse, if1.block_snapshot, if1.first_blocked_idx, 8'(if1.block_event_cnt));
      a_row[2] = actual(if2.kernel_block, if2.kernel_block_pulse, if2.block_snapshot, if2.first_blocked_idx, 8'(if2.block_event_cnt));
      a_row[3] = actual(if3.kernel_block, if3.kernel_block_pulse, if3.block_snapshot, if3.first_blocked_idx, 8'(if3.block_event_cnt));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (a_row[i] !== e_row[i]) begin
          errors++;
          $display("FAIL cycle %0d inst%0d blk/pulse/snap/idx/cnt got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   cyc, i, a_row[i].blk, a_row[i].pulse, a_row[i].snap, a_row[i].idx, a_row[i].cnt,
                   e_row[i].blk, e_row[i].pulse, e_row[i].snap, e_row[i].idx, e_row[i].cnt);
        end
      end
      if (if0.kernel_block_pulse === 1'b1) begin
        checks++;
        if (evt_q.size() == 0) begin
          errors++;
          $display("FAIL evt_a cycle %0d got unexpected entry pulse want none", cyc);
        end else begin
          e_evt = evt_q.pop_front();
          if ({if0.block_snapshot, if0.first_blocked_idx, if0.block_event_cnt} !== e_evt) begin
            errors++;
            $display("FAIL evt_a cycle %0d snap/idx/cnt got %b/%0d/%0d want %b/%0d/%0d", cyc,
                     if0.block_snapshot, if0.first_blocked_idx, if0.block_event_cnt,
                     e_evt.snap, e_evt.idx, e_evt.cnt);
          end
        end
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam logic [3:0] IDL1 = 4'b1101, BLK1 = 4'b0010;
  localparam logic [3:0] IDL2 = 4'b0011, BLK2 = 4'b1100;
  localparam logic [3:0] ALLI = 4'b1111, NONE = 4'b0000;

  initial begin
    set_in(1'b0, 1'b0, NONE, NONE, 2'b00);
    model_reset();
    @(posedge clk);
    #1;
    run(3, 1'b0, 1'b1, 1'b0, NONE, NONE, 2'b00);

    // Basic detection, then condition removal (sticky vs non-sticky), then clr.
    evt_q.push_back('{BLK1, 2'd1, 8'd1});
    run(19, 1'b1, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
    run(3,  1'b1, 1'b1, 1'b0, ALLI, NONE, 2'b00);
    run(1,  1'b1, 1'b1, 1'b1, ALLI, NONE, 2'b00);
    run(2,  1'b1, 1'b1, 1'b0, ALLI, NONE, 2'b00);

    // One-cycle external stall at cycle 10 restarts the filter.
    evt_q.push_back('{BLK2, 2'd2, 8'd2});
    run(10, 1'b1, 1'b1, 1'b0, IDL2, BLK2, 2'b00);
    run(1,  1'b1, 1'b1, 1'b0, IDL2, BLK2, 2'b01);
    run(18, 1'b1, 1'b1, 1'b0, IDL2, BLK2, 2'b00);
    run(1,  1'b1, 1'b1, 1'b1, ALLI, NONE, 2'b00);
    run(2,  1'b1, 1'b1, 1'b0, ALLI, NONE, 2'b00);

    // All idle is not deadlock; one busy instance is not deadlock.
    run(100, 1'b1, 1'b1, 1'b0, ALLI, NONE, 2'b00);
    run(40,  1'b1, 1'b1, 1'b0, 4'b1010, 4'b0100, 2'b00);

    // Counter saturation on the 2-bit variants, with clr colliding with entry.
    run(2, 1'b0, 1'b1, 1'b0, ALLI, NONE, 2'b00);
    for (int ep = 0; ep < 5; ep++) begin
      if (ep == 1) begin
        run(1, 1'b1, 1'b1, 1'b1, IDL1, BLK1, 2'b00);
        run(2, 1'b1, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
        run(1, 1'b1, 1'b1, 1'b1, IDL1, BLK1, 2'b00);
        run(1, 1'b1, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
      end else begin
        run(5, 1'b1, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
      end
      run(1, 1'b1, 1'b1, 1'b1, ALLI, NONE, 2'b00);
      run(1, 1'b1, 1'b1, 1'b0, ALLI, NONE, 2'b00);
    end

    // Async reset mid-suspect and mid-blocked; en=0 while blocked.
    run(2, 1'b0, 1'b1, 1'b0, ALLI, NONE, 2'b00);
    run(8, 1'b1, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
    run(2, 1'b0, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
    evt_q.push_back('{BLK1, 2'd1, 8'd1});
    run(18, 1'b1, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
    run(1,  1'b0, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
    evt_q.push_back('{BLK1, 2'd1, 8'd1});
    run(17, 1'b1, 1'b1, 1'b0, IDL1, BLK1, 2'b00);
    run(4,  1'b1, 1'b0, 1'b0, IDL1, BLK1, 2'b00);
    run(3,  1'b1, 1'b1, 1'b0, ALLI, NONE, 2'b00);

    begin
      row_t row;
      for (int i = 0; i < 4; i++) row[i] = m[i];
      exp_q.push_back(row);
    end
    @(negedge clk);
    #1;
    checks++;
    if (evt_q.size() != 0) begin
      errors++;
      $display("FAIL evt_a_remaining got %0d pending entries want 0", evt_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
